// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation and operand-select types
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic {
    OPR_A_RS1 = 1'b0,
    OPR_A_PC  = 1'b1
  } opr_a_sel_t;

  typedef enum logic {
    OPR_B_RS2 = 1'b0,
    OPR_B_IMM = 1'b1
  } opr_b_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - resolves one source register from MEM/WB forwards or held data
module fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [DATA_WIDTH-1:0]     held_data,
  input  logic                      mem_we,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  logic is_x0;
  logic mem_hit;
  logic wb_hit;

  assign is_x0   = (rs_addr == '0);
  assign mem_hit = mem_we && (mem_rd == rs_addr);
  assign wb_hit  = wb_we && (wb_rd == rs_addr);

  // MEM is younger than WB, so it wins when both match
  always_comb begin
    fwd_data = held_data;
    if (is_x0) begin
      fwd_data = '0;
    end else if (mem_hit) begin
      fwd_data = mem_data;
    end else if (wb_hit) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - decode-to-ALU register with forwarding and operand select
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_rd_we,
  input  alu_op_t                   in_alu_op,
  input  opr_a_sel_t                in_a_sel,
  input  opr_b_sel_t                in_b_sel,
  input  logic                      mem_fwd_we,
  input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
  input  logic                      wb_fwd_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     wb_fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output alu_op_t                   out_alu_op,
  output logic [DATA_WIDTH-1:0]     out_opr_a,
  output logic [DATA_WIDTH-1:0]     out_opr_b,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [DATA_WIDTH-1:0]     out_rs2_val,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_rd_we
);

  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [DATA_WIDTH-1:0]     rs2_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic                      rd_we_q;
  alu_op_t                   alu_op_q;
  opr_a_sel_t                a_sel_q;
  opr_b_sel_t                b_sel_q;

  logic                      load;
  logic                      wb_hit_in_rs1;
  logic                      wb_hit_in_rs2;
  logic                      wb_hit_q_rs1;
  logic                      wb_hit_q_rs2;
  logic [DATA_WIDTH-1:0]     rs1_fwd;
  logic [DATA_WIDTH-1:0]     rs2_fwd;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  assign wb_hit_in_rs1 = wb_fwd_we && (wb_fwd_rd == in_rs1_addr) && (in_rs1_addr != '0);
  assign wb_hit_in_rs2 = wb_fwd_we && (wb_fwd_rd == in_rs2_addr) && (in_rs2_addr != '0);
  assign wb_hit_q_rs1  = wb_fwd_we && (wb_fwd_rd == rs1_addr_q) && (rs1_addr_q != '0);
  assign wb_hit_q_rs2  = wb_fwd_we && (wb_fwd_rd == rs2_addr_q) && (rs2_addr_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // The regfile write in WB lands after decode read it, so both capture and
  // hold must absorb it or the value would be gone once WB moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      rd_we_q    <= 1'b0;
      alu_op_q   <= ALU_ADD;
      a_sel_q    <= OPR_A_RS1;
      b_sel_q    <= OPR_B_RS2;
    end else if (load) begin
      pc_q       <= in_pc;
      rs1_data_q <= wb_hit_in_rs1 ? wb_fwd_data : in_rs1_data;
      rs2_data_q <= wb_hit_in_rs2 ? wb_fwd_data : in_rs2_data;
      imm_q      <= in_imm;
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
      rd_addr_q  <= in_rd_addr;
      rd_we_q    <= in_rd_we;
      alu_op_q   <= in_alu_op;
      a_sel_q    <= in_a_sel;
      b_sel_q    <= in_b_sel;
    end else begin
      if (wb_hit_q_rs1) begin
        rs1_data_q <= wb_fwd_data;
      end
      if (wb_hit_q_rs2) begin
        rs2_data_q <= wb_fwd_data;
      end
    end
  end

  fwd_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .rs_addr  (rs1_addr_q),
    .held_data(rs1_data_q),
    .mem_we   (mem_fwd_we),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .fwd_data (rs1_fwd)
  );

  fwd_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .rs_addr  (rs2_addr_q),
    .held_data(rs2_data_q),
    .mem_we   (mem_fwd_we),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_we    (wb_fwd_we),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .fwd_data (rs2_fwd)
  );

  assign out_valid   = valid_q;
  assign out_alu_op  = alu_op_q;
  assign out_opr_a   = (a_sel_q == OPR_A_PC) ? pc_q : rs1_fwd;
  assign out_opr_b   = (b_sel_q == OPR_B_IMM) ? imm_q : rs2_fwd;
  assign out_pc      = pc_q;
  assign out_rs2_val = rs2_fwd;
  assign out_rd_addr = rd_addr_q;
  assign out_rd_we   = rd_we_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage
module tb_ex_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_rd_we;
  alu_op_t     in_alu_op;
  opr_a_sel_t  in_a_sel;
  opr_b_sel_t  in_b_sel;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_we;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        out_valid;
  logic        out_ready;
  alu_op_t     out_alu_op;
  logic [31:0] out_opr_a, out_opr_b, out_pc, out_rs2_val;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rd_we(in_rd_we), .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_opr_a(out_opr_a), .out_opr_b(out_opr_b), .out_pc(out_pc),
    .out_rs2_val(out_rs2_val), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the instruction currently held, as the spec describes it
  logic        m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic        m_rdwe;
  alu_op_t     m_op;
  opr_a_sel_t  m_asel;
  opr_b_sel_t  m_bsel;

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] held);
    if (a == 5'd0) return 32'd0;
    if (mem_fwd_we && mem_fwd_rd == a) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == a) return wb_fwd_data;
    return held;
  endfunction

  function automatic logic wb_writes(input logic [4:0] a);
    return wb_fwd_we && wb_fwd_rd == a && a != 5'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_pc <= 0; m_rs1 <= 0; m_rs2 <= 0; m_imm <= 0;
      m_rs1a <= 0; m_rs2a <= 0; m_rd <= 0; m_rdwe <= 1'b0;
      m_op <= ALU_ADD; m_asel <= OPR_A_RS1; m_bsel <= OPR_B_RS2;
    end else if (in_valid && (!m_valid || out_ready) && !flush) begin
      m_valid <= 1'b1;
      m_pc <= in_pc; m_imm <= in_imm;
      m_rs1 <= wb_writes(in_rs1_addr) ? wb_fwd_data : in_rs1_data;
      m_rs2 <= wb_writes(in_rs2_addr) ? wb_fwd_data : in_rs2_data;
      m_rs1a <= in_rs1_addr; m_rs2a <= in_rs2_addr; m_rd <= in_rd_addr; m_rdwe <= in_rd_we;
      m_op <= in_alu_op; m_asel <= in_a_sel; m_bsel <= in_b_sel;
    end else begin
      if (wb_writes(m_rs1a)) m_rs1 <= wb_fwd_data;
      if (wb_writes(m_rs2a)) m_rs2 <= wb_fwd_data;
      if (flush || out_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("out_alu_op", 32'(out_alu_op), 32'(m_op));
      chk("out_opr_a", out_opr_a, (m_asel == OPR_A_PC) ? m_pc : resolve(m_rs1a, m_rs1));
      chk("out_opr_b", out_opr_b, (m_bsel == OPR_B_IMM) ? m_imm : resolve(m_rs2a, m_rs2));
      chk("out_rs2_val", out_rs2_val, resolve(m_rs2a, m_rs2));
      chk("out_pc", out_pc, m_pc);
      chk("out_rd", 32'({out_rd_we, out_rd_addr}), 32'({m_rdwe, m_rd}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input alu_op_t op, input logic [31:0] pc,
                      input logic [4:0] r1, input logic [31:0] d1,
                      input logic [4:0] r2, input logic [31:0] d2,
                      input logic [31:0] imm, input logic [4:0] rd,
                      input opr_a_sel_t as, input opr_b_sel_t bs);
    in_valid = 1'b1; in_alu_op = op; in_pc = pc;
    in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
    in_imm = imm; in_rd_addr = rd; in_rd_we = (rd != 5'd0); in_a_sel = as; in_b_sel = bs;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_rd_we = 0;
    in_alu_op = ALU_SUB; in_a_sel = OPR_A_RS1; in_b_sel = OPR_B_RS2;
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;

    mid();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset opr_a", out_opr_a, 32'd0);
    chk("reset opr_b", out_opr_b, 32'd0);
    chk("reset alu_op", 32'(out_alu_op), 32'(ALU_ADD));

    out_ready = 1'b1;
    load(ALU_ADD, 32'h0, 5'd3, 32'd5, 5'd4, 32'd7, 32'd0, 5'd5, OPR_A_RS1, OPR_B_RS2);
    tick();
    load(ALU_SUB, 32'h4, 5'd6, 32'd10, 5'd7, 32'd20, 32'd0, 5'd6, OPR_A_RS1, OPR_B_RS2);
    mid();
    chk("load1 valid", 32'(out_valid), 32'd1);
    chk("load1 opr_a", out_opr_a, 32'd5);
    chk("load1 opr_b", out_opr_b, 32'd7);
    tick();
    load(ALU_XOR, 32'h8, 5'd1, 32'd3, 5'd2, 32'd9, 32'd0, 5'd7, OPR_A_RS1, OPR_B_RS2);
    mid();
    chk("b2b valid", 32'(out_valid), 32'd1);
    chk("b2b opr_a", out_opr_a, 32'd10);
    chk("b2b alu_op", 32'(out_alu_op), 32'(ALU_SUB));
    tick();
    in_valid = 1'b0;
    mid();
    chk("b2b3 opr_b", out_opr_b, 32'd9);
    tick();
    mid();
    chk("drained valid", 32'(out_valid), 32'd0);

    load(ALU_ADD, 32'h10, 5'd3, 32'd1, 5'd4, 32'd7, 32'd0, 5'd8, OPR_A_RS1, OPR_B_RS2);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h100;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'h200;
    mid();
    chk("mem over wb", out_opr_a, 32'h100);
    tick();
    mem_fwd_we = 1'b0;
    mid();
    chk("wb only", out_opr_a, 32'h200);
    tick();
    wb_fwd_we = 1'b0;
    mid();
    chk("wb retained", out_opr_a, 32'h200);

    tick();
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h55;
    load(ALU_AND, 32'h44, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd9, OPR_A_RS1, OPR_B_RS2);
    mid();
    chk("stall in_ready", 32'(in_ready), 32'd0);
    chk("stall wb opr_b", out_opr_b, 32'h55);
    tick();
    wb_fwd_we = 1'b0;
    mid();
    chk("stall kept opr_b", out_opr_b, 32'h55);
    chk("stall in_ready2", 32'(in_ready), 32'd0);
    chk("stall op held", 32'(out_alu_op), 32'(ALU_ADD));

    tick();
    out_ready = 1'b1;
    load(ALU_OR, 32'h20, 5'd0, 32'h1234, 5'd5, 32'd3, 32'd0, 5'd1, OPR_A_RS1, OPR_B_RS2);
    tick();
    in_valid = 1'b0;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD;
    mid();
    chk("x0 opr_a", out_opr_a, 32'd0);
    tick();
    mem_fwd_we = 1'b0;
    load(ALU_ADD, 32'h80, 5'd1, 32'h11, 5'd2, 32'h22, 32'hFFFFFFFC, 5'd3, OPR_A_PC, OPR_B_IMM);
    tick();
    in_valid = 1'b0;
    mid();
    chk("pc opr_a", out_opr_a, 32'h80);
    chk("imm opr_b", out_opr_b, 32'hFFFFFFFC);
    chk("store rs2_val", out_rs2_val, 32'h22);

    tick();
    load(ALU_ADD, 32'h0, 5'd9, 32'd1, 5'd10, 32'd2, 32'd0, 5'd4, OPR_A_RS1, OPR_B_RS2);
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd9; wb_fwd_data = 32'h77;
    tick();
    wb_fwd_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mid();
    chk("capture bypass", out_opr_a, 32'h77);

    tick();
    flush = 1'b1;
    load(ALU_SLL, 32'h90, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd5, OPR_A_RS1, OPR_B_RS2);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    mid();
    chk("flush held", 32'(out_valid), 32'd0);
    tick();
    out_ready = 1'b1; flush = 1'b1;
    load(ALU_SRA, 32'h94, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd5, OPR_A_RS1, OPR_B_RS2);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    mid();
    chk("flush incoming", 32'(out_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      tick();
      load(alu_op_t'(i), 32'(i * 4), 5'(i + 1), 32'(100 + i), 5'(i + 2), 32'(200 + i),
           32'(i * 3), 5'(i), opr_a_sel_t'(i % 2), opr_b_sel_t'((i / 2) % 2));
      out_ready = (i % 3) != 1;
      wb_fwd_we = (i % 2) == 0; wb_fwd_rd = 5'(i + 1); wb_fwd_data = 32'(300 + i);
      mem_fwd_we = (i % 4) == 3; mem_fwd_rd = 5'(i + 1); mem_fwd_data = 32'(400 + i);
    end
    tick();
    in_valid = 1'b0; wb_fwd_we = 1'b0; mem_fwd_we = 1'b0; out_ready = 1'b0;

    tick();
    load(ALU_ADD, 32'hA0, 5'd3, 32'd9, 5'd4, 32'd8, 32'd0, 5'd2, OPR_A_RS1, OPR_B_RS2);
    tick();
    in_valid = 1'b0;
    mid();
    chk("pre-rst valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(out_valid), 32'd0);
    chk("async rst opr_a", out_opr_a, 32'd0);
    tick();
    rst = 1'b0;
    mid();
    chk("post-rst valid", 32'(out_valid), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
